alu_exec_unit: RTL and testbench

- Parametrised execute-stage unit for the MIPS datapath.
- Takes the 3-bit main-control ALU class code and the 6-bit R-type funct field, decodes them internally, and performs the operation.
- Single-cycle integer ops return a registered result after one cycle. Unsigned multiply and divide run iteratively into internal HI/LO registers and are read back with MFHI/MFLO.
- Sits between the register-read stage and write-back, with a valid/ready handshake toward the issue logic.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/alu_op_decode.sv | 37 +++
 rtl/alu_exec_unit.sv | 174 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: control encodings, internal op set, FSM states.
package mips_pkg;

  // ALU class codes driven by main control
  localparam logic [2:0] UC_RTYPE = 3'b111;
  localparam logic [2:0] UC_ADDI  = 3'b000;
  localparam logic [2:0] UC_ANDI  = 3'b101;
  localparam logic [2:0] UC_SLTI  = 3'b010;
  localparam logic [2:0] UC_ORI   = 3'b110;

  // R-type funct field codes
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO, OP_ILL
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_BUSY, ST_DONE
  } state_e;

  // True for ops that run on the iterative multiply/divide datapath
  function automatic logic is_iterative(op_e op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of (ALU class, funct) into the internal op set.
// Kept standalone so hazard detection can reuse the same decode.
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [2:0] uc_i,
  input  logic [5:0] funct_i,
  output op_e        op_o
);

  // Map class/funct to an op; anything unrecognised is illegal
  always_comb begin
    op_o = OP_ILL;
    case (uc_i)
      UC_RTYPE: begin
        case (funct_i)
          FN_ADD:   op_o = OP_ADD;
          FN_SUB:   op_o = OP_SUB;
          FN_AND:   op_o = OP_AND;
          FN_OR:    op_o = OP_OR;
          FN_SLT:   op_o = OP_SLT;
          FN_MULTU: op_o = OP_MULTU;
          FN_DIVU:  op_o = OP_DIVU;
          FN_MFHI:  op_o = OP_MFHI;
          FN_MFLO:  op_o = OP_MFLO;
          default:  op_o = OP_ILL;
        endcase
      end
      UC_ADDI: op_o = OP_ADD;
      UC_ANDI: op_o = OP_AND;
      UC_SLTI: op_o = OP_SLT;
      UC_ORI:  op_o = OP_OR;
      default: op_o = OP_ILL;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle integer ops plus iterative
// unsigned multiply/divide into HI/LO, behind a valid/ready handshake.
module alu_exec_unit
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   uc,
  input  logic [5:0]   funct,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic         out_wr,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int CW = $clog2(W + 1);

  op_e           dec_op;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Iterative datapath: acc holds {HI-side, LO-side} working bits, m the fixed operand
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   m_q;
  logic           is_div_q;
  logic [W-1:0]   hi_q, lo_q;

  logic           out_valid_q, out_wr_q, err_q;
  logic [W-1:0]   result_q;

  // Shared W+1-bit adder/subtractor and per-step next value of acc
  logic [W:0]     add_x, add_y, add_s;
  logic           add_sub, add_co;
  logic [W+1:0]   add_full;
  logic [W-1:0]   rem_n;
  logic [2*W-1:0] acc_step;
  logic [W-1:0]   sc_result;

  alu_op_decode u_dec (
    .uc_i    (uc),
    .funct_i (funct),
    .op_o    (dec_op)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // FSM state and iteration counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: iterative ops spend W cycles in BUSY, then one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_iterative(dec_op)) begin
          state_d = ST_BUSY;
          cnt_d   = CW'(W);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  // Divide uses the adder's carry-out as "no borrow", which also makes a
  // zero divisor fall out naturally as quotient all-ones, remainder a.
  always_comb begin
    add_sub  = is_div_q;
    add_x    = is_div_q ? {acc_q[2*W-1:W], acc_q[W-1]} : {1'b0, acc_q[2*W-1:W]};
    add_y    = add_sub ? ~{1'b0, m_q} : {1'b0, m_q};
    add_full = {1'b0, add_x} + {1'b0, add_y} + {{(W+1){1'b0}}, add_sub};
    add_s    = add_full[W:0];
    add_co   = add_full[W+1];
    rem_n    = add_co ? add_s[W-1:0] : add_x[W-1:0];
    if (is_div_q) begin
      acc_step = {rem_n, acc_q[W-2:0], add_co};
    end else if (acc_q[0]) begin
      acc_step = {add_s, acc_q[W-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};
    end
  end

  // Result of the single-cycle ops
  always_comb begin
    sc_result = '0;
    case (dec_op)
      OP_ADD:  sc_result = a + b;
      OP_SUB:  sc_result = a - b;
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_SLT:  sc_result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: sc_result = hi_q;
      OP_MFLO: sc_result = lo_q;
      default: sc_result = '0;
    endcase
  end

  // Datapath, HI/LO and registered outputs; outputs hold between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      m_q         <= '0;
      is_div_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        case (dec_op)
          OP_MULTU: begin
            acc_q    <= {{W{1'b0}}, b};
            m_q      <= a;
            is_div_q <= 1'b0;
          end
          OP_DIVU: begin
            acc_q    <= {{W{1'b0}}, a};
            m_q      <= b;
            is_div_q <= 1'b1;
          end
          default: begin
            out_valid_q <= 1'b1;
            out_wr_q    <= (dec_op != OP_ILL);
            err_q       <= (dec_op == OP_ILL);
            result_q    <= sc_result;
          end
        endcase
      end
      if (state_q == ST_BUSY) begin
        acc_q <= acc_step;
        if (cnt_q == CW'(1)) begin
          hi_q        <= acc_step[2*W-1:W];
          lo_q        <= acc_step[W-1:0];
          out_valid_q <= 1'b1;
          out_wr_q    <= 1'b0;
          err_q       <= 1'b0;
          result_q    <= '0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_wr    = out_wr_q;
  assign err       = err_q;
  assign result    = result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: arithmetic reference model plus
// per-cycle output comparison and literal checks on directed vectors.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   uc = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid, out_wr, err;
  logic [W-1:0] result;

  alu_exec_unit #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .uc        (uc),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_wr    (out_wr),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int           due;
    bit           wr;
    bit           er;
    logic [W-1:0] res;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           busy_lo = -1;
  int           busy_hi = -1;
  bit           chk_en = 1'b0;
  logic [W-1:0] last_res = '0;
  bit           last_wr = 1'b0;
  bit           last_er = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  // Reference semantics of one op; also updates the model HI/LO
  task automatic model(input logic [2:0] u, input logic [5:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       output bit multi, output bit wr, output bit er,
                       output logic [W-1:0] r);
    logic [2*W-1:0] p;
    multi = 1'b0; wr = 1'b1; er = 1'b0; r = '0;
    if (u == 3'b111) begin
      case (f)
        6'b100000: r = x + y;
        6'b100010: r = x - y;
        6'b100100: r = x & y;
        6'b100101: r = x | y;
        6'b101010: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
        6'b011001: begin
          p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
          m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
          multi = 1'b1; wr = 1'b0;
        end
        6'b011011: begin
          if (y == 0) begin m_lo = '1; m_hi = x; end
          else begin m_lo = x / y; m_hi = x % y; end
          multi = 1'b1; wr = 1'b0;
        end
        6'b010000: r = m_hi;
        6'b010010: r = m_lo;
        default: begin er = 1'b1; wr = 1'b0; end
      endcase
    end else begin
      case (u)
        3'b000: r = x + y;
        3'b101: r = x & y;
        3'b010: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
        3'b110: r = x | y;
        default: begin er = 1'b1; wr = 1'b0; end
      endcase
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", in_ready, !(edge_n >= busy_lo && edge_n <= busy_hi));
      if (expq.size() > 0 && expq[0].due == edge_n) begin
        check("out_valid", out_valid, 1'b1);
        check("out_wr", out_wr, expq[0].wr);
        check("err", err, expq[0].er);
        check("result", result, expq[0].res);
        last_res = expq[0].res;
        last_wr  = expq[0].wr;
        last_er  = expq[0].er;
        void'(expq.pop_front());
      end else begin
        check("out_valid_idle", out_valid, 1'b0);
        check("hold_result", result, last_res);
        check("hold_out_wr", out_wr, last_wr);
        check("hold_err", err, last_er);
      end
    end
  end

  // Present one op, wait for the accepting edge, record the expectation
  task automatic issue(input logic [2:0] u, input logic [5:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y, output int e);
    int   waited;
    bit   multi, wr, er;
    exp_t t;
    logic [W-1:0] r;
    waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: in_ready=%0b, required 1", in_ready);
      e = -1;
      return;
    end
    uc = u; funct = f; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e = edge_n;
    model(u, f, x, y, multi, wr, er, r);
    t.due = multi ? e + W : e;
    t.wr  = wr;
    t.er  = er;
    t.res = r;
    expq.push_back(t);
    if (multi) begin
      busy_lo = e;
      busy_hi = e + W;
    end
  endtask

  // Issue and wait for the completion pulse; lat is in cycles after acceptance
  task automatic run_op(input logic [2:0] u, input logic [5:0] f,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output bit wr, output bit er,
                        output int lat, output int low);
    int e;
    issue(u, f, x, y, e);
    lat = -1; low = 0; r = '0; wr = 1'b0; er = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (in_ready === 1'b0) low++;
      if (out_valid === 1'b1) begin
        r = result; wr = out_wr; er = err;
        lat = edge_n - e + 1;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL run_op_timeout: out_valid not seen, required within %0d cycles", W + 10);
    end
  endtask

  // Single-cycle directed vector with a literal expected result
  task automatic vec(input string name, input logic [2:0] u, input logic [5:0] f,
                     input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] exp);
    logic [W-1:0] r;
    bit wr, er;
    int lat, low;
    run_op(u, f, x, y, r, wr, er, lat, low);
    check(name, r, exp);
    check({name, "_wr"}, wr, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: summary not reached in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    bit wr, er;
    int lat, low, e;

    // 1. Reset held three cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    run_op(3'b111, 6'b010000, 32'd5, 32'd6, r, wr, er, lat, low);
    check("rst_mfhi", r, 32'd0);
    check("rst_mfhi_wr", wr, 1'b1);

    // 2. SUB and SLTI
    run_op(3'b111, 6'b100010, 32'd5, 32'd7, r, wr, er, lat, low);
    check("sub_result", r, 32'hFFFF_FFFE);
    check("sub_wr", wr, 1'b1);
    check("sub_latency", lat, 1);
    vec("slti_neg", 3'b010, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd1);

    // Other single-cycle ops
    vec("add_wrap", 3'b111, 6'b100000, 32'hFFFF_FFFF, 32'd2, 32'd1);
    vec("and_r",    3'b111, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    vec("or_r",     3'b111, 6'b100101, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    vec("slt_pos",  3'b111, 6'b101010, 32'd3, 32'hFFFF_FFFF, 32'd0);
    vec("slt_lt",   3'b111, 6'b101010, 32'h8000_0000, 32'd0, 32'd1);
    vec("addi",     3'b000, 6'b111111, 32'd100, 32'hFFFF_FFFC, 32'd96);
    vec("andi",     3'b101, 6'b000000, 32'hABCD_EF12, 32'h0000_FFFF, 32'h0000_EF12);
    vec("ori",      3'b110, 6'b000000, 32'hABCD_0000, 32'h0000_00FF, 32'hABCD_00FF);

    // Back-to-back single-cycle ops, one per cycle
    for (int i = 0; i < 6; i++) issue(3'b111, 6'b100000, W'(i), W'(i * 3 + 1), e);
    repeat (3) @(negedge clk);

    // 3. MULTU then HI/LO readback in the first ready cycle
    run_op(3'b111, 6'b011001, 32'hFFFF_FFFF, 32'd2, r, wr, er, lat, low);
    check("multu_latency", lat, W + 1);
    check("multu_ready_low", low, W + 1);
    check("multu_wr", wr, 1'b0);
    check("multu_result", r, 32'd0);
    run_op(3'b111, 6'b010000, 32'd0, 32'd0, r, wr, er, lat, low);
    check("multu_hi", r, 32'd1);
    run_op(3'b111, 6'b010010, 32'd0, 32'd0, r, wr, er, lat, low);
    check("multu_lo", r, 32'hFFFF_FFFE);

    // Model-checked multiply with a dense operand pair
    run_op(3'b111, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, r, wr, er, lat, low);
    run_op(3'b111, 6'b010000, 32'd0, 32'd0, r, wr, er, lat, low);
    run_op(3'b111, 6'b010010, 32'd0, 32'd0, r, wr, er, lat, low);

    // 4. DIVU, including divide by zero
    run_op(3'b111, 6'b011011, 32'd100, 32'd7, r, wr, er, lat, low);
    check("divu_latency", lat, W + 1);
    run_op(3'b111, 6'b010010, 32'd0, 32'd0, r, wr, er, lat, low);
    check("divu_lo", r, 32'd14);
    run_op(3'b111, 6'b010000, 32'd0, 32'd0, r, wr, er, lat, low);
    check("divu_hi", r, 32'd2);
    run_op(3'b111, 6'b011011, 32'd9, 32'd0, r, wr, er, lat, low);
    check("div0_latency", lat, W + 1);
    run_op(3'b111, 6'b010010, 32'd0, 32'd0, r, wr, er, lat, low);
    check("div0_lo", r, 32'hFFFF_FFFF);
    run_op(3'b111, 6'b010000, 32'd0, 32'd0, r, wr, er, lat, low);
    check("div0_hi", r, 32'd9);

    // 5. Illegal funct and illegal class leave HI/LO alone
    run_op(3'b111, 6'b111111, 32'd1, 32'd2, r, wr, er, lat, low);
    check("ill_latency", lat, 1);
    check("ill_err", er, 1'b1);
    check("ill_wr", wr, 1'b0);
    check("ill_result", r, 32'd0);
    run_op(3'b011, 6'b100000, 32'd1, 32'd2, r, wr, er, lat, low);
    check("ill_uc_err", er, 1'b1);
    run_op(3'b111, 6'b010010, 32'd0, 32'd0, r, wr, er, lat, low);
    check("ill_lo_kept", r, 32'hFFFF_FFFF);

    // 6. Reset in the middle of a divide
    issue(3'b111, 6'b011011, 32'd100, 32'd7, e);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    expq.delete();
    m_hi = '0; m_lo = '0;
    busy_lo = -1; busy_hi = -1;
    last_res = '0; last_wr = 1'b0; last_er = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b1);
    repeat (W + 5) @(negedge clk);
    run_op(3'b111, 6'b010010, 32'd0, 32'd0, r, wr, er, lat, low);
    check("abort_lo", r, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
